// File: rtl/ifu_fetch_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response,
// and the {pc, inst} handshake toward the IF/ID register.
//   master : the fetch unit (drives imem request and out_* signals)
//   slave  : the environment (memory, branch resolution, decode side)
interface ifu_fetch_if #(
    parameter int PC_WIDTH   = 64,
    parameter int INST_WIDTH = 32
);
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [PC_WIDTH-1:0]   imem_req_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_inst;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0] out_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
        output out_valid, out_pc, out_inst,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
        input  out_valid, out_pc, out_inst,
        output out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Owns the fetch PC, keeps at most one
// instruction-memory request outstanding, and presents each fetched
// {pc, inst} pair to the IF/ID register over a valid/ready handshake.
// Redirects from branch/jump resolution take priority in every state.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ifu_fetch_if.master: redirect, imem request/response, out handshake
module ifu_fetch #(
    parameter int                     PC_WIDTH   = 64,
    parameter int                     INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic                  drop;
    logic                  out_valid;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0] out_inst;
    logic [PC_WIDTH-1:0]   redirect_target;

    // Low two bits of a redirect target are forced to zero.
    assign redirect_target = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    // A redirect suppresses the request in the same cycle so the stale
    // address is never issued.
    assign bus.imem_req_valid = (state == S_REQ) && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = out_pc;
    assign bus.out_inst       = out_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            drop        <= 1'b0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
        end else begin
            if (bus.redirect_valid)
                pc <= redirect_target;

            case (state)
                S_REQ: begin
                    if (bus.imem_req_valid && bus.imem_req_ready) begin
                        inflight_pc <= pc;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (drop || bus.redirect_valid) begin
                            // Response belongs to a squashed path.
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            out_pc    <= inflight_pc;
                            out_inst  <= bus.imem_resp_inst;
                            out_valid <= 1'b1;
                            pc        <= pc + PC_WIDTH'(4);
                            state     <= S_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        // Request already in flight: remember to discard it.
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect withdraws the pair even if out_ready is high.
                    if (bus.redirect_valid || bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam int PW = 64;
    localparam int IW = 32;

    typedef struct {
        logic          rv;
        logic [PW-1:0] rpc;
        logic          rdy;
        logic          rsv;
        logic [IW-1:0] rinst;
        logic          ordy;
        logic          e_rqv;
        logic [PW-1:0] e_addr;
        logic          e_ov;
        logic [PW-1:0] e_pc;
        logic [IW-1:0] e_inst;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    ifu_fetch_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

    ifu_fetch #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(64'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rv, input logic [PW-1:0] rpc, input logic rdy,
                                input logic rsv, input logic [IW-1:0] rinst, input logic ordy,
                                input logic e_rqv, input logic [PW-1:0] e_addr, input logic e_ov,
                                input logic [PW-1:0] e_pc, input logic [IW-1:0] e_inst);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsv = rsv; v.rinst = rinst; v.ordy = ordy;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic drive(input logic rv, input logic [PW-1:0] rpc, input logic rdy,
                         input logic rsv, input logic [IW-1:0] rinst, input logic ordy);
        bus.redirect_valid  = rv;
        bus.redirect_pc     = rpc;
        bus.imem_req_ready  = rdy;
        bus.imem_resp_valid = rsv;
        bus.imem_resp_inst  = rinst;
        bus.out_ready       = ordy;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        drive(0, '0, 0, 0, '0, 0);

        // Cycle-by-cycle vectors; expected values describe the state seen
        // just after the inputs are applied, before the next rising edge.
        //          rv rpc                    rdy rsv rinst         ordy  rqv addr                   ov pc                     inst
        // free run
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_0000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h8000_0000,1,    0, 64'h8000_0000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_0004,         1, 64'h8000_0000,        32'h8000_0000));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_0004,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h8000_0004,1,    0, 64'h8000_0004,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_0008,         1, 64'h8000_0004,        32'h8000_0004));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_0008,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h8000_0008,0,    0, 64'h8000_0008,         0, 0,                    0));
        // backpressure: held pair, no request, stray response ignored
        vecs.push_back(mk(0, 0,                    1, 0, 0,            0,    0, 64'h8000_000C,         1, 64'h8000_0008,        32'h8000_0008));
        vecs.push_back(mk(0, 0,                    1, 1, 32'hDEAD_BEEF,0,    0, 64'h8000_000C,         1, 64'h8000_0008,        32'h8000_0008));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            0,    0, 64'h8000_000C,         1, 64'h8000_0008,        32'h8000_0008));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            0,    0, 64'h8000_000C,         1, 64'h8000_0008,        32'h8000_0008));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_000C,         1, 64'h8000_0008,        32'h8000_0008));
        // memory wait states
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    1, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    1, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h1234_5678,1,    0, 64'h8000_000C,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_0010,         1, 64'h8000_000C,        32'h1234_5678));
        // redirect while waiting: response dropped
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_0010,         0, 0,                    0));
        vecs.push_back(mk(1, 64'h8000_1000,        0, 0, 0,            1,    0, 64'h8000_0010,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_1000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'hAAAA_AAAA,1,    0, 64'h8000_1000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_1000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h8000_1000,1,    0, 64'h8000_1000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h8000_1004,         1, 64'h8000_1000,        32'h8000_1000));
        // redirect in REQ suppresses the request
        vecs.push_back(mk(1, 64'h8000_3000,        1, 0, 0,            1,    0, 64'h8000_1004,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    1, 64'h8000_3000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_3000,         0, 0,                    0));
        // redirect with response same cycle, misaligned target
        vecs.push_back(mk(1, 64'h8000_2003,        0, 1, 32'hBBBB_BBBB,1,    0, 64'h8000_3000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h8000_2000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h1111_2222,0,    0, 64'h8000_2000,         0, 0,                    0));
        // redirect in HOLD with out_ready low
        vecs.push_back(mk(1, 64'h8000_4000,        0, 0, 0,            0,    0, 64'h8000_2004,         1, 64'h8000_2000,        32'h1111_2222));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    1, 64'h8000_4000,         0, 0,                    0));
        // PC wrap
        vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFF,0,0, 0,            1,    0, 64'h8000_4000,         0, 0,                    0));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'hCAFE_F00D,1,    0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            1,    0, 64'h0,                 1, 64'hFFFF_FFFF_FFFF_FFFC,32'hCAFE_F00D));
        vecs.push_back(mk(0, 0,                    1, 0, 0,            1,    1, 64'h0,                 0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 1, 32'h0000_0013,0,    0, 64'h0,                 0, 0,                    0));
        vecs.push_back(mk(0, 0,                    0, 0, 0,            0,    0, 64'h4,                 1, 64'h0,                32'h0000_0013));

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", PW'(bus.out_valid), 0);
        check("reset out_pc",    bus.out_pc, 0);
        check("reset out_inst",  PW'(bus.out_inst), 0);
        check("reset req_addr",  bus.imem_req_addr, 64'h8000_0000);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rsv, vecs[i].rinst, vecs[i].ordy);
            #1;
            check($sformatf("v%0d req_valid", i), PW'(bus.imem_req_valid), PW'(vecs[i].e_rqv));
            check($sformatf("v%0d req_addr", i),  bus.imem_req_addr, vecs[i].e_addr);
            check($sformatf("v%0d out_valid", i), PW'(bus.out_valid), PW'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_pc", i),   bus.out_pc, vecs[i].e_pc);
                check($sformatf("v%0d out_inst", i), PW'(bus.out_inst), PW'(vecs[i].e_inst));
            end
        end

        // Async reset while a pair is held: outputs clear without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", PW'(bus.out_valid), 0);
        check("async rst out_pc",    bus.out_pc, 0);
        check("async rst req_addr",  bus.imem_req_addr, 64'h8000_0000);

        @(negedge clk);
        rst = 1'b1;
        drive(0, '0, 1, 0, '0, 1);
        #1;
        check("restart req_valid", PW'(bus.imem_req_valid), 1);
        check("restart req_addr",  bus.imem_req_addr, 64'h8000_0000);

        @(negedge clk);
        drive(0, '0, 0, 0, '0, 1);
        #1;
        check("wait req_valid", PW'(bus.imem_req_valid), 0);

        // Reset mid-WAIT, then a late response must be ignored.
        rst = 1'b0;
        #1;
        check("rst in wait req_valid", PW'(bus.imem_req_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, '0, 0, 1, 32'hDEAD_0001, 1);
        #1;
        check("late resp req_valid", PW'(bus.imem_req_valid), 1);
        @(negedge clk);
        drive(0, '0, 0, 0, '0, 1);
        #1;
        check("late resp out_valid", PW'(bus.out_valid), 0);
        check("late resp req_valid2", PW'(bus.imem_req_valid), 1);
        check("late resp req_addr",  bus.imem_req_addr, 64'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
